// File: rtl/fast_bridge_pkg.sv
// Shared fast-bridge constants and the credit-slack helper, common to both link ends.
package fast_bridge_pkg;

    localparam int FB_DATA_WIDTH        = 32;
    localparam int FB_READY_LATENCY     = 1;
    localparam int FB_EXT_PIPE_DEPTH    = 1;
    localparam int FB_FIFO_DEPTH        = 16;

    // Beats that can still land after s0_ready drops: ready path, source latency,
    // data path, plus the credit register itself.
    function automatic int fb_skid(input int ready_latency, input int ext_pipe_depth);
        return ready_latency + 2 * ext_pipe_depth + 1;
    endfunction

endpackage

// File: rtl/fast_bridge_sink_fifo.sv
// Register-array first-word-fall-through FIFO with occupancy count and next-count lookahead.
module fast_bridge_sink_fifo
    import fast_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic [$clog2(FIFO_DEPTH):0]   count_next,
    output logic                          empty,
    output logic                          full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full buffer still takes a beat when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fast_bridge_sink.sv
// Receive end of the fast bridge: absorbs ready-latency beats and re-presents them valid/ready.
module fast_bridge_sink
    import fast_bridge_pkg::*;
#(
    parameter int DATA_WIDTH          = FB_DATA_WIDTH,
    parameter int READY_LATENCY       = FB_READY_LATENCY,
    parameter int EXTERNAL_PIPE_DEPTH = FB_EXT_PIPE_DEPTH,
    parameter int FIFO_DEPTH          = FB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  s0_ready,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_valid,
    input  logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_data,
    output logic                  m0_valid,
    output logic                  overflow_err
);

    localparam int SKID = fb_skid(READY_LATENCY, EXTERNAL_PIPE_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_LIMIT = CW'(FIFO_DEPTH - SKID);

    generate
        if (FIFO_DEPTH < SKID + 1) begin : g_depth_too_small
            $error("fast_bridge_sink: FIFO_DEPTH must be at least SKID+1");
        end
        if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_not_pow2
            $error("fast_bridge_sink: FIFO_DEPTH must be a power of two");
        end
    endgenerate

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          pop;

    assign m0_valid = ~empty;
    assign pop      = m0_valid & m0_ready;

    fast_bridge_sink_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s0_valid),
        .push_data (s0_data),
        .pop       (pop),
        .pop_data  (m0_data),
        .count     (count),
        .count_next(count_next),
        .empty     (empty),
        .full      (full)
    );

    // Credit tracks the post-edge occupancy so a pop returns credit one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_ready     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            s0_ready <= (count_next <= CREDIT_LIMIT);
            if (s0_valid & full & ~pop) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fast_bridge_sink.sv
// Bench for fast_bridge_sink: queue-based reference model checked every cycle, plus directed pins.
module tb_fast_bridge_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_ready;
    logic [31:0] s0_data;
    logic        s0_valid;
    logic        m0_ready;
    logic [31:0] m0_data;
    logic        m0_valid;
    logic        overflow_err;

    fast_bridge_sink dut (
        .clk         (clk),
        .reset       (reset),
        .s0_ready    (s0_ready),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .m0_ready    (m0_ready),
        .m0_data     (m0_data),
        .m0_valid    (m0_valid),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a buffer of at most 16 beats with credit threshold 16-4.
    logic [31:0] q[$];
    logic        m_rdy = 1'b0;
    logic        m_ovf = 1'b0;
    int          npop  = 0;
    bit          en    = 1'b0;

    always @(posedge clk) begin : model
        if (reset) begin
            q.delete();
            m_rdy = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (q.size() > 0 && m0_ready) begin
                void'(q.pop_front());
                npop++;
            end
            if (s0_valid) begin
                if (q.size() < 16) q.push_back(s0_data);
                else m_ovf = 1'b1;
            end
            m_rdy = (q.size() <= 12);
        end
    end

    always @(negedge clk) begin : compare
        if (en) begin
            chk("m0_valid", {31'b0, m0_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) chk("m0_data", m0_data, q[0]);
            chk("s0_ready", {31'b0, s0_ready}, {31'b0, m_rdy});
            chk("overflow_err", {31'b0, overflow_err}, {31'b0, m_ovf});
        end
    end

    // Compliant source: may send in cycle c only if s0_ready was high in cycle c-3.
    logic [3:0] hist = '0;
    logic [31:0] nxt;

    task automatic tick();
        @(posedge clk);
        #2;
        hist = {hist[2:0], s0_ready};
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        s0_valid = 1'b0;
        m0_ready = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic fill_stalled(input int cycles);
        m0_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            s0_valid = hist[3];
            s0_data  = nxt;
            if (hist[3]) nxt++;
            tick();
        end
        s0_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        s0_valid = 1'b0;
        s0_data  = '0;
        m0_ready = 1'b0;
        tick();
        en = 1'b1;
        tick();
        chk("rst_s0_ready", {31'b0, s0_ready}, 32'd0);
        chk("rst_m0_valid", {31'b0, m0_valid}, 32'd0);
        chk("rst_m0_data", m0_data, 32'd0);
        chk("rst_overflow", {31'b0, overflow_err}, 32'd0);

        // Release and first beat
        reset = 1'b0;
        tick();
        chk("release_ready", {31'b0, s0_ready}, 32'd1);
        s0_valid = 1'b1;
        s0_data  = 32'hA5A5_0001;
        tick();
        s0_valid = 1'b0;
        chk("first_valid", {31'b0, m0_valid}, 32'd1);
        chk("first_data", m0_data, 32'hA5A5_0001);
        m0_ready = 1'b1;
        tick();
        chk("first_drained", {31'b0, m0_valid}, 32'd0);

        // Stalled consumer: in-flight beats fill exactly to 16
        nxt = 32'h100;
        fill_stalled(30);
        chk("fill_model", q.size(), 32'd16);
        chk("fill_ready_low", {31'b0, s0_ready}, 32'd0);
        chk("fill_no_ovf", {31'b0, overflow_err}, 32'd0);

        // Full with simultaneous pop: beat accepted, no error
        m0_ready = 1'b1;
        s0_valid = 1'b1;
        s0_data  = 32'h0000_BEEF;
        tick();
        s0_valid = 1'b0;
        m0_ready = 1'b0;
        chk("accept_head", m0_data, 32'h0000_0101);
        chk("accept_no_ovf", {31'b0, overflow_err}, 32'd0);

        // Full without pop: beat dropped, sticky error
        s0_valid = 1'b1;
        s0_data  = 32'h0000_DEAD;
        tick();
        s0_valid = 1'b0;
        chk("ovf_set", {31'b0, overflow_err}, 32'd1);
        repeat (3) tick();
        chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);

        // Drain in order; the accepted beat is last, the dropped one never appears
        m0_ready = 1'b1;
        repeat (15) tick();
        chk("drain_last", m0_data, 32'h0000_BEEF);
        tick();
        chk("drain_empty", {31'b0, m0_valid}, 32'd0);
        chk("ovf_after_drain", {31'b0, overflow_err}, 32'd1);

        // Full-rate streaming with random consumer
        do_reset(2);
        nxt = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            m0_ready = 1'($urandom_range(0, 1));
            s0_valid = hist[3];
            s0_data  = nxt;
            if (hist[3]) nxt++;
            tick();
        end
        s0_valid = 1'b0;
        m0_ready = 1'b1;
        repeat (20) tick();
        chk("stream_no_ovf", {31'b0, overflow_err}, 32'd0);
        chk("stream_drained", {31'b0, m0_valid}, 32'd0);

        // Pointer wrap: 0..99 with occupancy swinging 0 to 3
        begin
            int base;
            int v;
            base = npop;
            v = 0;
            while (v < 100) begin
                m0_ready = 1'b0;
                for (int k = 0; k < 3 && v < 100; k++) begin
                    s0_valid = 1'b1;
                    s0_data  = v;
                    v++;
                    tick();
                end
                s0_valid = 1'b0;
                m0_ready = 1'b1;
                repeat (3) tick();
            end
            chk("wrap_count", npop - base, 32'd100);
        end

        // Reset mid-operation with 9 beats buffered
        m0_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s0_valid = 1'b1;
            s0_data  = 32'h900 + k;
            tick();
        end
        chk("pre_reset_model", q.size(), 32'd9);
        reset    = 1'b1;
        s0_valid = 1'b1;
        s0_data  = 32'h0000_0BAD;
        tick();
        chk("in_reset_ready", {31'b0, s0_ready}, 32'd0);
        tick();
        s0_valid = 1'b0;
        reset    = 1'b0;
        tick();
        chk("post_reset_valid", {31'b0, m0_valid}, 32'd0);
        chk("post_reset_ovf", {31'b0, overflow_err}, 32'd0);
        chk("post_reset_ready", {31'b0, s0_ready}, 32'd1);
        s0_valid = 1'b1;
        s0_data  = 32'h0000_0077;
        tick();
        s0_valid = 1'b0;
        chk("post_reset_data", m0_data, 32'h0000_0077);
        m0_ready = 1'b1;
        repeat (3) tick();

        en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
